// File: rtl/mux4_scan_seq.sv
// Scans a 4:1 mux by stepping sel through 0..3 with a programmable dwell per channel,
// capturing mux_out per channel and publishing a registered 4-bit frame with a done pulse.
module mux4_scan_seq #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       done,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_shadow;
  logic             r_cont_q;
  logic             r_stop_q;
  logic [1:0]       r_sel;
  logic [3:0]       r_sample;
  logic             r_done;
  logic             r_busy;
  logic [7:0]       r_frame_cnt;

  logic w_dwell_end;
  assign w_dwell_end = (r_cnt == DWELL_M1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_cont_q    <= 1'b0;
      r_stop_q    <= 1'b0;
      r_sel       <= 2'd0;
      r_sample    <= 4'd0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sel  <= 2'd0;
          r_busy <= 1'b0;
          if (start) begin
            r_state  <= ST_SCAN;
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_cont_q <= cont;
            r_stop_q <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (stop && r_cont_q) r_stop_q <= 1'b1;
          if (w_dwell_end) begin
            r_cnt <= '0;
            if (r_sel != 2'd3) begin
              case (r_sel)
                2'd0:    r_shadow[0] <= mux_out;
                2'd1:    r_shadow[1] <= mux_out;
                default: r_shadow[2] <= mux_out;
              endcase
              r_sel <= r_sel + 2'd1;
            end else begin
              // Last channel goes straight into the frame so sample never shows a partial update.
              r_sample    <= {mux_out, r_shadow};
              r_done      <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 8'd1;
              r_sel       <= 2'd0;
              if (!(r_cont_q && !r_stop_q)) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel       = r_sel;
  assign sample    = r_sample;
  assign done      = r_done;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_mux4_scan_seq.sv
// Bench for mux4_scan_seq: DWELL=2 and DWELL=1 instances checked every cycle against a frame-position model.
module tb_mux4_scan_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start2, cont2, stop2, start1, cont1, stop1;
  logic [3:0] ip2, ip1;
  logic       mux2, mux1;
  logic [1:0] sel2, sel1;
  logic [3:0] sample2, sample1;
  logic       done2, done1, busy2, busy1;
  logic [7:0] fc2, fc1;

  assign mux2 = ip2[sel2];
  assign mux1 = ip1[sel1];

  mux4_scan_seq #(.DWELL(2), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cont(cont2), .stop(stop2), .mux_out(mux2),
    .sel(sel2), .sample(sample2), .done(done2), .busy(busy2), .frame_cnt(fc2));

  mux4_scan_seq #(.DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cont(cont1), .stop(stop1), .mux_out(mux1),
    .sel(sel1), .sample(sample1), .done(done1), .busy(busy1), .frame_cnt(fc1));

  // Model tracks position (cycles elapsed) within the current frame rather than sel/counter.
  typedef struct packed {
    logic        busy;
    logic [15:0] pos;
    logic [3:0]  bits;
    logic        cont_q;
    logic        stop_q;
    logic [3:0]  sample;
    logic [7:0]  fc;
    logic        done;
  } model_t;

  model_t m2, m1, n2, n1;
  int n_asserts = 0;
  int n_fail    = 0;

  function automatic model_t mstep(model_t m, int d, logic rn, logic st, logic ct,
                                   logic sp, logic [3:0] ip);
    model_t n;
    int     p, k;
    n = m;
    if (!rn) return '0;
    n.done = 1'b0;
    if (!m.busy) begin
      if (st) begin
        n.busy = 1'b1; n.pos = 16'd0; n.cont_q = ct; n.stop_q = 1'b0;
      end
    end else begin
      if (sp && m.cont_q) n.stop_q = 1'b1;
      p = int'(m.pos);
      k = p / d;
      if (p % d == d - 1) n.bits[k] = ip[k];
      p = p + 1;
      n.pos = 16'(p);
      if (p == 4 * d) begin
        n.sample = n.bits;
        n.done   = 1'b1;
        n.fc     = m.fc + 8'd1;
        n.pos    = 16'd0;
        if (!(m.cont_q && !m.stop_q)) n.busy = 1'b0;
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] exp_sel(model_t m, int d);
    if (!m.busy) return 2'd0;
    return 2'(int'(m.pos) / d);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    n2 = mstep(m2, 2, rst_n, start2, cont2, stop2, ip2);
    n1 = mstep(m1, 1, rst_n, start1, cont1, stop1, ip1);
    @(posedge clk);
    #1;
    m2 = n2;
    m1 = n1;
    chk("d2_sel",    {6'd0, sel2},    {6'd0, exp_sel(m2, 2)});
    chk("d2_busy",   {7'd0, busy2},   {7'd0, m2.busy});
    chk("d2_done",   {7'd0, done2},   {7'd0, m2.done});
    chk("d2_sample", {4'd0, sample2}, {4'd0, m2.sample});
    chk("d2_fc",     fc2,             m2.fc);
    chk("d1_sel",    {6'd0, sel1},    {6'd0, exp_sel(m1, 1)});
    chk("d1_busy",   {7'd0, busy1},   {7'd0, m1.busy});
    chk("d1_done",   {7'd0, done1},   {7'd0, m1.done});
    chk("d1_sample", {4'd0, sample1}, {4'd0, m1.sample});
    chk("d1_fc",     fc1,             m1.fc);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [1:0] sel_seq [8];

  initial begin
    sel_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    m2 = '0; m1 = '0;
    rst_n = 1'b0;
    start2 = 0; cont2 = 0; stop2 = 0; start1 = 0; cont1 = 0; stop1 = 0;
    ip2 = 4'd0; ip1 = 4'd0;

    // Reset state
    ticks(2);
    chk("rst_sel", {6'd0, sel2}, 8'd0);
    chk("rst_busy", {7'd0, busy2}, 8'd0);
    chk("rst_sample", {4'd0, sample2}, 8'd0);
    chk("rst_fc", fc2, 8'd0);
    rst_n = 1'b1;
    ticks(2);

    // Single frame, DWELL=2
    ip2 = 4'b1010; start2 = 1; tick(); start2 = 0;
    for (int i = 0; i < 8; i++) begin
      chk("single_sel_seq", {6'd0, sel2}, {6'd0, sel_seq[i]});
      chk("single_no_done", {7'd0, done2}, 8'd0);
      tick();
    end
    chk("single_done", {7'd0, done2}, 8'd1);
    chk("single_sample", {4'd0, sample2}, 8'b1010);
    chk("single_fc", fc2, 8'd1);
    chk("single_busy_low", {7'd0, busy2}, 8'd0);
    ticks(3);

    // Continuous: two frames with a pattern change between them
    ip2 = 4'b0110; cont2 = 1; start2 = 1; tick(); start2 = 0; cont2 = 0;
    ticks(8);
    chk("cont_done1", {7'd0, done2}, 8'd1);
    chk("cont_sample1", {4'd0, sample2}, 8'b0110);
    chk("cont_fc1", fc2, 8'd2);
    ip2 = 4'b1001;
    ticks(8);
    chk("cont_done2", {7'd0, done2}, 8'd1);
    chk("cont_sample2", {4'd0, sample2}, 8'b1001);
    chk("cont_fc2", fc2, 8'd3);

    // Stop pulse while sel=1, frame completes then idles
    ip2 = 4'($urandom);
    ticks(2);
    chk("stop_at_sel1", {6'd0, sel2}, 8'd1);
    stop2 = 1; tick(); stop2 = 0;
    ticks(5);
    chk("stop_done", {7'd0, done2}, 8'd1);
    chk("stop_sample", {4'd0, sample2}, {4'd0, ip2});
    chk("stop_busy_low", {7'd0, busy2}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stop_idle_sel", {6'd0, sel2}, 8'd0);
      chk("stop_idle_busy", {7'd0, busy2}, 8'd0);
    end

    // Reset mid-scan with sel=2
    ip2 = 4'b1111; start2 = 1; tick(); start2 = 0;
    ticks(4);
    chk("midrst_sel2", {6'd0, sel2}, 8'd2);
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    chk("midrst_sel", {6'd0, sel2}, 8'd0);
    chk("midrst_busy", {7'd0, busy2}, 8'd0);
    chk("midrst_sample", {4'd0, sample2}, 8'd0);
    chk("midrst_fc", fc2, 8'd0);
    chk("midrst_done", {7'd0, done2}, 8'd0);
    ticks(10);
    chk("midrst_no_done", {7'd0, done2}, 8'd0);

    // DWELL=1 with start held high throughout
    ip1 = 4'b0001; start1 = 1; tick();
    for (int i = 0; i < 4; i++) begin
      chk("d1_sel_step", {6'd0, sel1}, 8'(i));
      chk("d1_busy_held", {7'd0, busy1}, 8'd1);
      tick();
    end
    chk("d1_done", {7'd0, done1}, 8'd1);
    chk("d1_sample", {4'd0, sample1}, 8'b0001);
    chk("d1_busy_low", {7'd0, busy1}, 8'd0);
    tick();
    chk("d1_restart", {7'd0, busy1}, 8'd1);
    start1 = 0;
    ticks(6);

    // Frame counter wrap over 256 continuous frames
    cont2 = 1; start2 = 1; ip2 = 4'($urandom); tick(); start2 = 0; cont2 = 0;
    for (int f = 0; f < 256; f++) begin
      ticks(8);
      chk("wrap_done", {7'd0, done2}, 8'd1);
      chk("wrap_fc", fc2, 8'((f + 1) % 256));
      ip2 = 4'($urandom);
    end
    chk("wrap_fc_zero", fc2, 8'd0);
    chk("wrap_still_busy", {7'd0, busy2}, 8'd1);
    stop2 = 1; tick(); stop2 = 0;
    ticks(10);

    // Randomized control on both instances
    for (int i = 0; i < 400; i++) begin
      start2 = 1'($urandom_range(0, 3) == 0);
      cont2  = 1'($urandom);
      stop2  = 1'($urandom_range(0, 15) == 0);
      start1 = 1'($urandom_range(0, 3) == 0);
      cont1  = 1'($urandom);
      stop1  = 1'($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) ip2 = 4'($urandom);
      if ($urandom_range(0, 7) == 0) ip1 = 4'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_scan_seq.md
Name: mux4_scan_seq

Overview:
- Sequencer that sits directly upstream of the 4:1 gate-level mux.
- Drives the mux select lines through channels 0→3, holds each for a programmable dwell, and captures the mux output bit for each channel.
- Publishes a registered 4-bit frame (one bit per channel) with a done pulse.
- Supports single-shot and continuous scan; control logic uses it to read four slow status lines over a single mux output wire.

Parameters:
- DWELL, 2, cycles sel is held per channel before sampling; legal range 1..255.
- CNT_W, 8, width of dwell counter; must satisfy 2^CNT_W > DWELL.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin scan; sampled only in IDLE
- cont  input  1  1 = continuous scan, 0 = single frame; latched at start acceptance
- stop  input  1  in continuous mode, finish current frame then return to IDLE
- mux_out  input  1  output of the 4:1 mux being scanned
- sel  output  2  select lines to the mux (sel[0]=s0, sel[1]=s1)
- sample  output  4  last completed frame; bit k = mux_out captured with sel=k
- done  output  1  one-cycle pulse when sample updates
- busy  output  1  high while in SCAN
- frame_cnt  output  8  completed-frame counter, wraps 255→0

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; sel=0; sample=0; done=0; busy=0; frame_cnt=0.
  - Dwell counter, shadow register, and the latched cont and stop flags are all cleared.
  - Reset overrides every other input, including mid-scan; the partially captured frame is discarded.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, SCAN.
- IDLE:
  - busy=0; sel is held at 0.
  - start=1 → at the next edge: SCAN, sel=0, cnt=0, cont_q=cont, stop_q=0.
- SCAN:
  - busy=1.
  - Each cycle cnt increments. When cnt==DWELL-1: shadow[sel]=mux_out and cnt=0.
  - If sel<3: sel=sel+1.
  - If sel==3 (frame end):
    - sample={mux_out, shadow[2:0]}; done=1 in the following cycle; frame_cnt+1.
    - If cont_q=1 and stop_q=0: sel=0 and remain in SCAN.
    - Otherwise: IDLE with sel=0.
- stop handling:
  - stop=1 in any SCAN cycle sets stop_q (sticky until IDLE).
  - stop is ignored in IDLE and in single-shot mode.
- start is ignored while in SCAN; cont changes while in SCAN have no effect.
- Timing:
  - Let cycle T be the cycle where start is accepted. sel=k is driven for cycles T+1+k·DWELL … T+(k+1)·DWELL.
  - done is high in cycle T+4·DWELL+1 with sample valid in that same cycle.
  - Continuous mode: back-to-back frames, one done every 4·DWELL cycles, no idle gap.
- After a single frame, busy=0 in the same cycle done=1. start asserted in that cycle begins a new frame immediately.
- DWELL=1: a capture occurs every SCAN cycle and sel advances every cycle.
- frame_cnt wraps modulo 256 silently.
- sample holds its value between frames and is never partially updated.

Test Plan:
- Reset: rst_n=0 for 2 cycles mid-SCAN with sel=2 → next cycle sel=0, busy=0, sample=0, frame_cnt=0, no done.
- Single frame, DWELL=2: mux_out modeled as i[sel] with i=4'b1010; pulse start → done at T+9, sample=4'b1010, frame_cnt=1, busy low at T+9, sel sequence 0,0,1,1,2,2,3,3.
- Continuous: cont=1, i changes from 4'b0110 to 4'b1001 between frames → done every 8 cycles; successive sample values 0110 then 1001; frame_cnt increments each frame.
- Stop mid-frame: in continuous mode assert stop for 1 cycle while sel=1 → current frame completes with done; then IDLE; no further sel activity.
- DWELL=1 edge case plus start during SCAN: i=4'b0001, start held high throughout → start is not re-accepted mid-frame; done at T+5 with sample=0001; new frame begins immediately because start is still high in IDLE.
- Wrap: run 256 continuous frames → frame_cnt returns to 0 and scanning continues uninterrupted.
